// File: rtl/reg_scoreboard.sv
// Purpose: per-register in-flight producer tracker; counts pending writers per
//          architectural register and answers ID-stage hazard/load-use queries.
// Latency: issue/retire/flush take effect at the clock edge; queries are
//          combinational from registered state (visible the cycle after an update).
// Backpressure: none; the block never stalls.  It only reports hazards so the
//          stall logic can hold ID.  A saturated counter raises sticky overflow_err.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   flush                     clear all in-flight state (redirect)
//   issue_valid/rd/is_load    destination of the instruction entering EX
//   retire_valid/rd           destination of the instruction writing back
//   rs1_addr, rs2_addr        ID-stage source registers being queried
//   hazard_rs1/rs2            source has at least one pending producer
//   producer_is_load_rs1/rs2  youngest pending producer of the source is a load
//   sb_empty                  no register has a pending producer
//   overflow_err              sticky: an issue found its counter saturated

module reg_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int CNT_W    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic              issue_is_load,
    input  logic              retire_valid,
    input  logic [ADDR_W-1:0] retire_rd,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic              hazard_rs1,
    output logic              hazard_rs2,
    output logic              producer_is_load_rs1,
    output logic              producer_is_load_rs2,
    output logic              sb_empty,
    output logic              overflow_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Flattened per-register views; bit 0 is x0, which never has a producer.
    logic [NUM_REGS-1:0] busy_vec;
    logic [NUM_REGS-1:0] ld_vec;
    logic [NUM_REGS-1:0] sat_vec;

    assign busy_vec[0] = 1'b0;
    assign ld_vec[0]   = 1'b0;
    assign sat_vec[0]  = 1'b0;

    // ------------------------------------------------------------------
    // Per-register state: pending-writer count and youngest-is-load flag.
    // ------------------------------------------------------------------
    for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
        logic [CNT_W-1:0] cnt;
        logic             ld;
        logic             iss;
        logic             ret;

        assign iss = issue_valid  && (issue_rd  == ADDR_W'(r));
        assign ret = retire_valid && (retire_rd == ADDR_W'(r));

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt <= '0;
                ld  <= 1'b0;
            end else if (flush) begin
                cnt <= '0;
                ld  <= 1'b0;
            end else if (iss && ret) begin
                // One writer leaves while another enters: count is unchanged,
                // and the newcomer is now the youngest producer.
                ld <= issue_is_load;
            end else if (iss) begin
                ld <= issue_is_load;
                if (cnt != CNT_MAX) begin
                    cnt <= cnt + CNT_ONE;
                end
            end else if (ret && (cnt != '0)) begin
                cnt <= cnt - CNT_ONE;
                if (cnt == CNT_ONE) begin
                    ld <= 1'b0;
                end
            end
        end

        assign busy_vec[r] = (cnt != '0);
        assign ld_vec[r]   = ld;
        assign sat_vec[r]  = (cnt == CNT_MAX);
    end

    // ------------------------------------------------------------------
    // Overflow detection: an issue to a saturated counter that is not
    // offset by a same-register retire and not cancelled by a flush.
    // ------------------------------------------------------------------
    logic same_rd;
    logic issue_sat;

    assign same_rd   = retire_valid && (retire_rd == issue_rd);
    assign issue_sat = issue_valid && (issue_rd != '0) && sat_vec[issue_rd]
                       && !same_rd && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_err <= 1'b0;
        end else if (issue_sat) begin
            overflow_err <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Queries: registered state only, no same-cycle bypass.  x0 reads as
    // idle through bit 0 of the flattened vectors.
    // ------------------------------------------------------------------
    assign hazard_rs1           = busy_vec[rs1_addr];
    assign hazard_rs2           = busy_vec[rs2_addr];
    assign producer_is_load_rs1 = hazard_rs1 && ld_vec[rs1_addr];
    assign producer_is_load_rs2 = hazard_rs2 && ld_vec[rs2_addr];
    assign sb_empty             = ~(|busy_vec);

endmodule

// File: tb/tb_reg_scoreboard.sv
module tb_reg_scoreboard;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       issue_valid;
    logic [4:0] issue_rd;
    logic       issue_is_load;
    logic       retire_valid;
    logic [4:0] retire_rd;
    logic [4:0] rs1_addr;
    logic [4:0] rs2_addr;
    logic       hazard_rs1;
    logic       hazard_rs2;
    logic       producer_is_load_rs1;
    logic       producer_is_load_rs2;
    logic       sb_empty;
    logic       overflow_err;

    reg_scoreboard #(.NUM_REGS(32), .ADDR_W(5), .CNT_W(2)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .flush                (flush),
        .issue_valid          (issue_valid),
        .issue_rd             (issue_rd),
        .issue_is_load        (issue_is_load),
        .retire_valid         (retire_valid),
        .retire_rd            (retire_rd),
        .rs1_addr             (rs1_addr),
        .rs2_addr             (rs2_addr),
        .hazard_rs1           (hazard_rs1),
        .hazard_rs2           (hazard_rs2),
        .producer_is_load_rs1 (producer_is_load_rs1),
        .producer_is_load_rs2 (producer_is_load_rs2),
        .sb_empty             (sb_empty),
        .overflow_err         (overflow_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       fl;
        logic       iv;
        logic [4:0] ird;
        logic       il;
        logic       rv;
        logic [4:0] rrd;
        logic [4:0] q1;
        logic [4:0] q2;
    } stim_t;

    typedef struct {
        logic h1;
        logic h2;
        logic l1;
        logic l2;
        logic em;
        logic ov;
    } exp_t;

    typedef struct {
        stim_t s;
        exp_t  e;
    } vec_t;

    vec_t tbl[$];
    exp_t exp_q[$];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int idx, input logic act, input logic want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s step %0d: got %b expected %b", name, idx, act, want);
        end
    endtask

    task automatic check_all(input int idx, input exp_t e);
        check("hazard_rs1", idx, hazard_rs1, e.h1);
        check("hazard_rs2", idx, hazard_rs2, e.h2);
        check("producer_is_load_rs1", idx, producer_is_load_rs1, e.l1);
        check("producer_is_load_rs2", idx, producer_is_load_rs2, e.l2);
        check("sb_empty", idx, sb_empty, e.em);
        check("overflow_err", idx, overflow_err, e.ov);
    endtask

    task automatic add(input logic fl, input logic iv, input int ird, input logic il,
                       input logic rv, input int rrd, input int q1, input int q2,
                       input logic h1, input logic h2, input logic l1, input logic l2,
                       input logic em, input logic ov);
        vec_t v;
        v.s.fl  = fl;
        v.s.iv  = iv;
        v.s.ird = 5'(ird);
        v.s.il  = il;
        v.s.rv  = rv;
        v.s.rrd = 5'(rrd);
        v.s.q1  = 5'(q1);
        v.s.q2  = 5'(q2);
        v.e.h1  = h1;
        v.e.h2  = h2;
        v.e.l1  = l1;
        v.e.l2  = l2;
        v.e.em  = em;
        v.e.ov  = ov;
        tbl.push_back(v);
    endtask

    task automatic drive_idle();
        flush         = 1'b0;
        issue_valid   = 1'b0;
        issue_rd      = '0;
        issue_is_load = 1'b0;
        retire_valid  = 1'b0;
        retire_rd     = '0;
    endtask

    initial begin
        exp_t e;
        exp_t idle_e;

        // Each row: inputs applied before an edge, outputs checked just after it
        // while the same query addresses are held.
        //   fl iv ird il rv rrd q1 q2   h1 h2 l1 l2 em ov
        add(0, 0, 0, 0, 0, 0, 5, 0,    0, 0, 0, 0, 1, 0); // 0  idle after reset
        add(0, 1, 5, 1, 0, 0, 5, 0,    1, 0, 1, 0, 0, 0); // 1  issue x5 load
        add(0, 0, 0, 0, 1, 5, 5, 0,    0, 0, 0, 0, 1, 0); // 2  retire x5
        add(0, 1, 7, 1, 0, 0, 0, 7,    0, 1, 0, 1, 0, 0); // 3  issue x7 load
        add(0, 1, 7, 0, 0, 0, 0, 7,    0, 1, 0, 0, 0, 0); // 4  issue x7 ALU (WAW)
        add(0, 0, 0, 0, 1, 7, 0, 7,    0, 1, 0, 0, 0, 0); // 5  one retire, still pending
        add(0, 0, 0, 0, 1, 7, 0, 7,    0, 0, 0, 0, 1, 0); // 6  second retire clears
        add(0, 0, 0, 0, 1, 7, 0, 7,    0, 0, 0, 0, 1, 0); // 7  retire at zero ignored
        add(0, 1, 3, 0, 0, 0, 3, 0,    1, 0, 0, 0, 0, 0); // 8  issue x3 ALU
        add(0, 1, 3, 1, 1, 3, 3, 0,    1, 0, 1, 0, 0, 0); // 9  issue+retire x3, load wins
        add(0, 0, 0, 0, 1, 3, 3, 0,    0, 0, 0, 0, 1, 0); // 10 count stayed 1
        add(0, 1, 9, 1, 0, 0, 9, 0,    1, 0, 1, 0, 0, 0); // 11 x9 cnt 1
        add(0, 1, 9, 0, 0, 0, 9, 0,    1, 0, 0, 0, 0, 0); // 12 x9 cnt 2
        add(0, 1, 9, 0, 0, 0, 9, 0,    1, 0, 0, 0, 0, 0); // 13 x9 cnt 3
        add(0, 1, 9, 1, 1, 9, 9, 0,    1, 0, 1, 0, 0, 0); // 14 issue+retire at max: no error
        add(0, 1, 9, 0, 0, 0, 9, 0,    1, 0, 0, 0, 0, 1); // 15 fourth issue saturates
        add(0, 0, 0, 0, 1, 9, 9, 0,    1, 0, 0, 0, 0, 1); // 16 held at 3 -> now 2
        add(1, 1, 4, 1, 0, 0, 9, 4,    0, 0, 0, 0, 1, 1); // 17 flush beats issue x4
        add(0, 1, 0, 1, 0, 0, 0, 0,    0, 0, 0, 0, 1, 1); // 18 issue to x0 ignored
        add(0, 0, 0, 0, 1, 0, 0, 0,    0, 0, 0, 0, 1, 1); // 19 retire x0 ignored
        add(0, 1, 12, 0, 0, 0, 12, 13, 1, 0, 0, 0, 0, 1); // 20 issue x12
        add(0, 1, 13, 1, 1, 12, 12, 13, 0, 1, 0, 1, 0, 1); // 21 issue x13, retire x12
        add(0, 0, 0, 0, 1, 13, 12, 13, 0, 0, 0, 0, 1, 1); // 22 retire x13

        // Reset: outputs must be idle while rst is held.
        drive_idle();
        rs1_addr = 5'd5;
        rs2_addr = 5'd0;
        rst      = 1'b1;
        #2;
        idle_e = '{h1: 1'b0, h2: 1'b0, l1: 1'b0, l2: 1'b0, em: 1'b1, ov: 1'b0};
        check_all(-1, idle_e);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            @(negedge clk);
            flush         = tbl[i].s.fl;
            issue_valid   = tbl[i].s.iv;
            issue_rd      = tbl[i].s.ird;
            issue_is_load = tbl[i].s.il;
            retire_valid  = tbl[i].s.rv;
            retire_rd     = tbl[i].s.rrd;
            rs1_addr      = tbl[i].s.q1;
            rs2_addr      = tbl[i].s.q2;
            exp_q.push_back(tbl[i].e);
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL scoreboard step %0d: queue empty", i);
            end else begin
                e = exp_q.pop_front();
                check_all(i, e);
            end
        end

        // No same-cycle bypass: an issue is invisible until after its edge.
        @(negedge clk);
        drive_idle();
        issue_valid = 1'b1;
        issue_rd    = 5'd6;
        rs1_addr    = 5'd6;
        rs2_addr    = 5'd0;
        #1;
        check("no_bypass_hazard", 100, hazard_rs1, 1'b0);
        check("no_bypass_empty", 100, sb_empty, 1'b1);
        @(posedge clk);
        #1;
        check("issue_visible", 101, hazard_rs1, 1'b1);
        @(negedge clk);
        drive_idle();
        check("ovf_still_set", 102, overflow_err, 1'b1);

        // Asynchronous reset between edges clears everything immediately.
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_ovf", 103, overflow_err, 1'b0);
        check("async_rst_hazard", 103, hazard_rs1, 1'b0);
        check("async_rst_empty", 103, sb_empty, 1'b1);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("after_rst_hazard", 104, hazard_rs1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Per-register in-flight producer tracker for the 3-stage RV32I pipeline.
- Records destination registers as instructions issue from ID into EX, and clears them at writeback retire.
- Answers ID-stage source queries with hazard_rs1/hazard_rs2 and producer_is_load_rs1/rs2; these feed the load-use stall logic.
- Handles multiple outstanding writers to one register (WAW) and pipeline flush.

Parameters:
NUM_REGS, 32, number of architectural registers tracked (x0 never tracked)
ADDR_W, 5, register address width
CNT_W, 2, width of per-register pending-writer counter

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
flush  input  1  clear all in-flight state (branch/jump redirect)
issue_valid  input  1  instruction with a destination leaves ID into EX this cycle
issue_rd  input  ADDR_W  destination register of the issuing instruction
issue_is_load  input  1  issuing instruction is a load
retire_valid  input  1  instruction writes back this cycle
retire_rd  input  ADDR_W  destination register of the retiring instruction
rs1_addr  input  ADDR_W  ID-stage source 1
rs2_addr  input  ADDR_W  ID-stage source 2
hazard_rs1  output  1  rs1 has a pending producer
hazard_rs2  output  1  rs2 has a pending producer
producer_is_load_rs1  output  1  youngest pending producer of rs1 is a load
producer_is_load_rs2  output  1  youngest pending producer of rs2 is a load
sb_empty  output  1  no register has a pending producer
overflow_err  output  1  sticky: an issue hit a saturated counter

Behaviour:
- State per register r (1..NUM_REGS-1): cnt[r] (CNT_W bits) and ld[r] (1 bit). Register 0 has no storage and always reads as cnt=0, ld=0.
- Reset (async, rst=1): all cnt=0, all ld=0, overflow_err=0. Outputs during and after reset: hazard_*=0, producer_is_load_*=0, sb_empty=1.
- Issue (edge, issue_valid=1, issue_rd!=0, no flush):
  - cnt[rd] += 1 and ld[rd] <= issue_is_load, so the youngest producer's type wins.
  - If cnt[rd] is already at the maximum (2^CNT_W-1): cnt holds, ld still updates, and overflow_err is set to 1.
- Retire (edge, retire_valid=1, retire_rd!=0, no flush):
  - cnt[rd] -= 1, saturating at 0. A retire at cnt=0 is ignored and does not set an error.
  - When cnt goes 1->0, ld[rd] <= 0.
- Simultaneous issue and retire, same rd:
  - cnt unchanged (including at max, where there is no overflow).
  - ld <= issue_is_load.
- Simultaneous issue and retire, different rd: both updates apply independently.
- issue_rd=0 or retire_rd=0: no state change.
- Flush (edge, flush=1): all cnt=0 and all ld=0. This overrides issue and retire in the same cycle. overflow_err is not cleared; only rst clears it.
- Queries are combinational from registered state only. There is no bypass of same-cycle issue or retire.
  - hazard_rsN = (rsN_addr!=0) && (cnt[rsN_addr]!=0)
  - producer_is_load_rsN = hazard_rsN && ld[rsN_addr]
- Query latency: an issue at edge T is visible to queries from cycle T+1. A retire at edge T clears the hazard from cycle T+1.
- sb_empty = 1 when every cnt is 0. It is combinational from registered state.
- rst asserted mid-operation clears everything immediately, independent of clk.

Test Plan:
- Reset, then query rs1=5, rs2=0 -> hazard_rs1=0, hazard_rs2=0, sb_empty=1, overflow_err=0.
- Issue rd=5, is_load=1 at edge T; query rs1=5 at T+1 -> hazard_rs1=1, producer_is_load_rs1=1, sb_empty=0. Retire rd=5 at T+1 edge -> at T+2 hazard_rs1=0, producer_is_load_rs1=0, sb_empty=1.
- WAW sequence:
  - Issue rd=7 load, then issue rd=7 ALU -> hazard_rs2=1 (rs2=7), producer_is_load_rs2=0.
  - One retire rd=7 -> hazard_rs2 still 1.
  - Second retire -> hazard_rs2=0.
- Same-cycle issue and retire rd=3 (cnt=1 before, issue_is_load=1) -> cnt stays 1, producer_is_load_rs1=1 for rs1=3.
- Three issues to rd=9 (cnt=3), then a fourth -> cnt stays 3, overflow_err=1. Flush -> hazard on rd=9 = 0, sb_empty=1, overflow_err remains 1. Async rst pulse between clock edges -> overflow_err=0 immediately.
- Issue rd=0 with is_load=1 and query rs1=0 -> hazard_rs1=0, sb_empty=1. Flush asserted together with issue rd=4 -> hazard on rd=4 = 0 the next cycle.
